// File: rtl/fibonacci_bcd_converter.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// One bit per clock; digits update only when a conversion completes.
module fibonacci_bcd_converter (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bin_in,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t      state;
  logic [19:0] sr;
  logic [2:0]  cnt;
  logic [11:0] res;
  logic [19:0] adj;
  logic [19:0] nxt;

  // Add-3 correction on each BCD nibble, then the left shift.
  always_comb begin
    adj = sr;
    if (sr[11:8] >= 4'd5)
      adj[11:8] = sr[11:8] + 4'd3;
    if (sr[15:12] >= 4'd5)
      adj[15:12] = sr[15:12] + 4'd3;
    if (sr[19:16] >= 4'd5)
      adj[19:16] = sr[19:16] + 4'd3;
    nxt = {adj[18:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr    <= {12'h000, bin_in};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            res   <= nxt[19:8];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign hundreds = res[11:8];
  assign tens     = res[7:4];
  assign ones     = res[3:0];

endmodule

// File: tb/tb_fibonacci_bcd_converter.sv
// Scoreboard bench for fibonacci_bcd_converter: expected digits are
// queued at each accepting edge and compared when done fires.
module tb_fibonacci_bcd_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bin_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [11:0] q[$];
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_rst = 1'b0;
  logic [3:0]  m_cnt = '0;
  logic [11:0] m_dig = '0;

  fibonacci_bcd_converter dut (
    .clk(clk),
    .reset(reset),
    .bin_in(bin_in),
    .start(start),
    .busy(busy),
    .done(done),
    .hundreds(hundreds),
    .tens(tens),
    .ones(ones)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] bcd(int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Timing model of the handshake: accept only when idle.
  always @(posedge clk) begin
    m_rst  <= reset;
    m_done <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      q.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy <= 1'b1;
        m_cnt  <= '0;
        q.push_back(bcd(int'(bin_in)));
      end
    end else begin
      m_cnt <= m_cnt + 4'd1;
      if (m_cnt == 4'd7) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      if (m_rst)
        m_dig = '0;
      if (done === 1'b1) begin
        if (q.size() == 0)
          check("spurious_done", 1, 0);
        else
          m_dig = q.pop_front();
      end
      check("digits", int'({hundreds, tens, ones}), int'(m_dig));
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL timeout: got %0d cycles expected <= 20000", cyc);
      $fatal(1);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic convert(logic [7:0] v);
    bin_in = v;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = ~v;
    tick(10);
  endtask

  logic [7:0] fa, fb, fn;
  logic [7:0] vals[4] = '{8'd144, 8'd233, 8'd0, 8'd255};

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 8'd77;
    @(posedge clk);
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_digits", int'({hundreds, tens, ones}), 0);
    tick(3);

    foreach (vals[i])
      convert(vals[i]);

    // start pulses and bin_in changes mid-conversion must be ignored
    bin_in = 8'd89;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    bin_in = 8'd55;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(12);
    check("hold_089", int'({hundreds, tens, ones}), 12'h089);

    // back-to-back with start held high
    bin_in = 8'd13;
    start  = 1'b1;
    tick();
    bin_in = 8'd21;
    tick(9);
    start = 1'b0;
    tick(10);
    check("b2b_021", int'({hundreds, tens, ones}), 12'h021);

    // reset in the 4th conversion cycle aborts
    bin_in = 8'd200;
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    tick(10);
    check("abort_digits", int'({hundreds, tens, ones}), 0);
    convert(8'd34);
    check("post_abort_034", int'({hundreds, tens, ones}), 12'h034);

    // free-running 8-bit Fibonacci source, start held high
    fa = 8'd0;
    fb = 8'd1;
    bin_in = fa;
    start  = 1'b1;
    repeat (200) begin
      tick();
      fn = fa + fb;
      fa = fb;
      fb = fn;
      bin_in = fa;
    end
    start = 1'b0;
    tick(12);

    check("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fibonacci_bcd_converter.md
# fibonacci_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 8-bit Fibonacci generator. It samples one 8-bit term on a start handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents three BCD digits for display or logging. The block is multi-cycle by design, so a controller (or bench) chooses which generator terms to convert.

## Interface

- None. Data width is fixed at 8 bits to match the generator output. Output is fixed at 3 BCD digits, since the maximum value is 255.

- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `bin_in` in 8: unsigned term from the Fibonacci generator; sampled only on an accepted start.
- `start` in 1: conversion request; accepted only while idle.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: single-cycle pulse when `hundreds/tens/ones` are updated.
- `hundreds` out 4: BCD hundreds digit (0–2).
- `tens` out 4: BCD tens digit (0–9).
- `ones` out 4: BCD ones digit (0–9).

## Operation

- Two states: IDLE and CONV.
- Internal registers:
  - 20-bit shift register `{bcd[11:0], bin[7:0]}`.
  - 3-bit iteration counter.
  - 12-bit output register.
- IDLE, `start`=1: load shift register with `{12'h000, bin_in}`, clear counter, go to CONV.
- IDLE, `start`=0: hold; outputs unchanged.
- CONV, each edge, in this order:
  - For each BCD nibble of the shift register ≥5, add 3 to that nibble.
  - Shift the whole 20-bit register left by 1.
  - Increment the counter.
- CONV, edge where counter = 7 (8th iteration):
  - Write the post-shift upper 12 bits to `{hundreds, tens, ones}`.
  - Pulse `done`.
  - Return to IDLE.
- `start` during CONV is ignored; no queuing and no effect on the running conversion. `bin_in` changes during CONV have no effect.
- Outputs `hundreds/tens/ones` hold the last completed result until the next conversion completes. They never show intermediate values.
- `busy` = (state == CONV), registered.
- Reset:
  - State goes to IDLE; counter and shift register clear.
  - `busy`=0, `done`=0, `hundreds`=`tens`=`ones`=0.
  - Reset during CONV aborts the conversion; no `done` is issued.
  - Reset has priority over `start` on the same edge.

## Timing

- Start accepted on edge k (IDLE and `start`=1). `busy`=1 from after edge k.
- Iterations execute on edges k+1 … k+8.
- After edge k+8:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - Digits are valid from then on.
- Latency: 8 cycles from the accepting edge to `done`.
- Back-to-back: `start` held high in the `done` cycle is accepted on edge k+9. Maximum throughput is one conversion per 9 cycles.
- `start` held continuously high behaves as repeated back-to-back conversions, each re-sampling `bin_in` at its accepting edge.
- The Fibonacci generator updates every cycle. The converted term is whatever `bin_in` holds at the accepting edge. That includes 8-bit wrapped terms (generator overflow is not the converter's concern).
- `done` and the digit update happen on the same edge. Downstream may sample the digits any time after `done` until the next `done`.

## Test plan

- Reset then idle: assert `reset` 2 cycles with `start`=1 → `busy`=0, `done`=0, digits 0/0/0. No conversion starts.
- Basic conversions:
  - `bin_in`=144, start 1 cycle → `done` exactly 8 cycles after accept with 1/4/4, `busy` high 8 cycles.
  - Repeat for 233 → 2/3/3.
  - Repeat for 0 → 0/0/0.
  - Repeat for 255 → 2/5/5.
- Ignored start and input hold: start with 89, then pulse `start` and change `bin_in` to 55 at cycles 3 and 5 of CONV → single `done` with 0/8/9. No second conversion; digits held afterwards.
- Back-to-back: `start` held high, `bin_in`=13 then 21 at successive accepting edges → `done` pulses 9 cycles apart, results 0/1/3 then 0/2/1.
- Reset mid-conversion: start with 200, assert `reset` at the 4th CONV cycle → no `done`, `busy` low after that edge, digits 0/0/0. A new start with 34 → 0/3/4 after 8 cycles.
- Connected to `fibonacci_adder` after reset, converting every term sampled on consecutive accepts → each result equals the decimal value of the sampled term, checked against a bench model.
